// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes a selectable pattern to every RAM location,
// reads everything back and reports pass/fail, error count and first failure.
module mem_bist_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 2**ADDR_W,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    output logic              read,
    output logic              write,
    input  logic [DATA_W-1:0] data_out
);

    localparam int unsigned DR_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [DR_W-1:0]   LAST_DRAIN = DR_W'(READ_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FINISH} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;
    logic                read_q, read_d, write_q, write_d;
    logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]   fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
    logic [1:0]          mode_q, mode_d;
    logic [DR_W-1:0]     drain_q, drain_d;
    logic                pv_q [READ_LAT];
    logic                pv_d [READ_LAT];
    logic [ADDR_W-1:0]   pa_q [READ_LAT];
    logic [ADDR_W-1:0]   pa_d [READ_LAT];
    logic [DATA_W-1:0]   pe_q [READ_LAT];
    logic [DATA_W-1:0]   pe_d [READ_LAT];
    logic                cmp_fail;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        p = '0;
        case (m)
            2'd0: p = DATA_W'(a);
            2'd1: for (int unsigned i = 0; i < DATA_W; i++) p[i] = (i % 2 == 0) ? ~a[0] : a[0];
            2'd2: p = ~DATA_W'(a);
            default: p = DATA_W'(1) << (32'(a) % DATA_W);
        endcase
        return p;
    endfunction

    // Oldest outstanding read is checked against the RAM output this cycle
    assign cmp_fail = pv_q[READ_LAT-1] && (data_out != pe_q[READ_LAT-1]);

    always_comb begin
        state_d     = state_q;
        addr_d      = '0;
        data_in_d   = '0;
        read_d      = 1'b0;
        write_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        mode_d      = mode_q;
        drain_d     = drain_q;

        pv_d[0] = read_q;
        pa_d[0] = addr_q;
        pe_d[0] = pattern(mode_q, addr_q);
        for (int unsigned i = 1; i < READ_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
            pe_d[i] = pe_q[i-1];
        end

        if (cmp_fail) begin
            if (err_q == '0) begin
                fail_addr_d = pa_q[READ_LAT-1];
                fail_exp_d  = pe_q[READ_LAT-1];
                fail_got_d  = data_out;
            end
            if (err_q != '1) err_d = err_q + ERR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    mode_d      = mode;
                    err_d       = '0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                end
            end
            S_WRITE: begin
                if (addr_q == LAST_ADDR) state_d = S_READ;
                else                     addr_d  = addr_q + ADDR_W'(1);
            end
            S_READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == LAST_DRAIN) state_d = S_FINISH;
                else                       drain_d = drain_q + DR_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs follow the state being entered
        case (state_d)
            S_WRITE: begin
                write_d   = 1'b1;
                busy_d    = 1'b1;
                data_in_d = pattern(mode_d, addr_d);
            end
            S_READ: begin
                read_d = 1'b1;
                busy_d = 1'b1;
            end
            S_DRAIN: busy_d = 1'b1;
            S_FINISH: begin
                done_d = 1'b1;
                pass_d = (err_d == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_in_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            mode_q      <= '0;
            drain_q     <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
                pe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_in_q   <= data_in_d;
            read_q      <= read_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            mode_q      <= mode_d;
            drain_q     <= drain_d;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pv_q[i] <= pv_d[i];
                pa_q[i] <= pa_d[i];
                pe_q[i] <= pe_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_got  = fail_got_q;
    assign addr      = addr_q;
    assign data_in   = data_in_q;
    assign read      = read_q;
    assign write     = write_q;

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
Synthesizable, parametrised memory built-in self-test controller. It drives a single-port synchronous RAM through the standard addr/data_in/read/write/data_out interface. The sequence writes every location with a selectable pattern, then reads every location back and compares it against the expected value. Results are reported as done, pass, an error count and first-failure capture. It replaces the hand-driven write-then-read-back memory test with a reusable block that can sit beside any RAM in the design.

Parameters:
DATA_W, 8, memory data width in bits (>=2)
ADDR_W, 5, memory address width
DEPTH, 2**ADDR_W, number of locations tested (addresses 0..DEPTH-1, DEPTH<=2**ADDR_W)
READ_LAT, 1, cycles from read asserted to data_out valid (1..4)
ERR_W, 8, error counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a test when sampled high in IDLE
mode  in  2  pattern select, sampled at start
busy  out  1  test in progress
done  out  1  one-cycle pulse at test end
pass  out  1  1 when the last completed test had zero errors
err_count  out  ERR_W  mismatches in last test, saturating
fail_addr  out  ADDR_W  address of first mismatch
fail_exp  out  DATA_W  expected data at first mismatch
fail_got  out  DATA_W  read data at first mismatch
addr  out  ADDR_W  memory address
data_in  out  DATA_W  memory write data
read  out  1  memory read strobe
write  out  1  memory write strobe
data_out  in  DATA_W  memory read data

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs are 0, including busy, done, pass, err_count, fail_* and addr/data_in/read/write.
  - Reset mid-test aborts immediately. Strobes drop asynchronously, with no further memory access.
- Pattern P(a), computed combinationally from the address counter and the latched mode:
  - mode 0, address-as-data: a zero-extended or truncated to DATA_W.
  - mode 1, checkerboard: 0x55.. for even a, 0xAA.. for odd a.
  - mode 2, inverse address: ~P0(a).
  - mode 3, walking one: 1 << (a mod DATA_W).
- States:
  - IDLE to WRITE on start. Latch mode, clear err_count, clear fail_* and pass.
  - WRITE: one write per cycle. write=1, read=0, addr=a, data_in=P(a), a=0..DEPTH-1. After a=DEPTH-1, go to READ with a=0.
  - READ: one read per cycle. read=1, write=0, addr=a, a=0..DEPTH-1. After a=DEPTH-1, go to DRAIN.
  - DRAIN: READ_LAT cycles with no strobes, so outstanding reads can be compared.
  - FINISH: done=1 for one cycle, busy=0, pass=(err_count==0). Then go to IDLE.
- Read checking:
  - The expected value and address travel in a READ_LAT-deep shift pipeline alongside each issued read.
  - data_out is compared exactly READ_LAT cycles after the read cycle.
  - On mismatch: err_count increments, saturating at 2**ERR_W-1.
  - On the first mismatch only: fail_addr, fail_exp and fail_got are captured. They hold until the next start.
- Timing: start high at cycle 0 in IDLE gives:
  - busy=1 and first write at cycle 1.
  - Last write at cycle DEPTH.
  - Reads at cycles DEPTH+1..2*DEPTH.
  - Last compare at 2*DEPTH+READ_LAT.
  - done at 2*DEPTH+READ_LAT+1.
- busy=1 from the first write through the last DRAIN cycle, and 0 in IDLE and FINISH.
- read and write are never high together. data_in is 0 when write=0. addr is 0 in IDLE, DRAIN and FINISH.
- start is ignored while not in IDLE, including FINISH. mode changes mid-test have no effect.
- pass, err_count and fail_* hold after done until the next accepted start.
- Address counter width is ADDR_W. The terminal count is DEPTH-1, with no wrap beyond DEPTH.

Test Plan:
- Fault-free RAM model, defaults, mode 0, start at cycle 0:
  - 32 writes with data==addr, then 32 reads.
  - done pulses at cycle 66, pass=1, err_count=0, fail_*=0.
- RAM model with bit 0 stuck-at-0 at addr 5, mode 0:
  - err_count=1, pass=0.
  - fail_addr=5, fail_exp=0x05, fail_got=0x04.
- Same stuck bit, mode 1:
  - Addr 5 is odd, so the expected value is 0xAA, which has bit 0 = 0. No fault is exposed: pass=1.
  - Repeat with the fault at addr 4: err_count=1, fail_exp=0x55, fail_got=0x54.
- READ_LAT=3, ERR_W=3, RAM that always returns 0x00, mode 2:
  - Every compare fails.
  - err_count saturates at 7, and fail_addr=0, fail_exp=0xFF.
  - done at cycle 68.
- Pulse start again at cycle 10 of a running test, and toggle mode:
  - No restart, done still at cycle 66, results reflect the original mode.
- Assert rst_n=0 at cycle 40, during READ:
  - read and write drop at once, and all outputs are 0.
  - A subsequent start runs a full clean test.
